// File: rtl/cpu_regfiles_mc.sv
// cpu_regfiles_mc: architectural GPR/FPR register files for the commit stage.
// Accepts up to COMMIT in-order retirements per cycle. When several slots write
// the same register in one cycle, the highest-numbered slot wins.
// Issue-side reads are combinational and see the current cycle's commits
// through a write-through bypass.
// A retired-instruction counter (instret) is kept alongside the arrays.
module cpu_regfiles_mc #(
  parameter int         DATA     = 32,
  parameter int         ADDR     = 32,
  parameter int         GPR_ADDR = 5,
  parameter int         FPR_ADDR = 5,
  parameter int         READ     = 2,
  parameter int         COMMIT   = 2,
  parameter int         CNT      = 64,
  parameter logic [1:0] TYPE_GPR = 2'd1,
  parameter logic [1:0] TYPE_FPR = 2'd2
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [READ*GPR_ADDR-1:0]   issue_gpr_addr,
  output logic [READ*DATA-1:0]       issue_gpr_data,
  input  logic [READ*FPR_ADDR-1:0]   issue_fpr_addr,
  output logic [READ*DATA-1:0]       issue_fpr_data,
  input  logic [COMMIT-1:0]          commit_e_,
  input  logic [COMMIT-1:0]          commit_jump_,
  input  logic [COMMIT*2-1:0]        commit_regtype,
  input  logic [COMMIT*GPR_ADDR-1:0] commit_addr,
  input  logic [COMMIT*DATA-1:0]     commit_data,
  input  logic [COMMIT*ADDR-1:0]     commit_pc,
  output logic [CNT-1:0]             instret
);

  localparam int NGPR = 1 << GPR_ADDR;
  localparam int NFPR = 1 << FPR_ADDR;

  // Architectural state. The arrays need an asynchronous clear of every entry,
  // so they are built from flops rather than RAM.
  logic [DATA-1:0] r_gpr [NGPR];
  logic [DATA-1:0] r_fpr [NFPR];
  logic [CNT-1:0]  r_instret;

  // Per-slot write decode
  logic [COMMIT-1:0]   w_gpr_we;
  logic [COMMIT-1:0]   w_fpr_we;
  logic [GPR_ADDR-1:0] w_gpr_idx   [COMMIT];
  logic [FPR_ADDR-1:0] w_fpr_idx   [COMMIT];
  logic [DATA-1:0]     w_gpr_wdata [COMMIT];
  logic [DATA-1:0]     w_fpr_wdata [COMMIT];
  logic [CNT-1:0]      w_retire;

  genvar gi;

  generate
    for (gi = 0; gi < COMMIT; gi++) begin : g_slot
      logic [1:0]      w_type;
      logic [ADDR-1:0] w_link;
      logic [DATA-1:0] w_data;

      assign w_type = commit_regtype[gi*2 +: 2];
      assign w_data = commit_data[gi*DATA +: DATA];

      // The link address wraps in PC width, then is resized to the data width.
      assign w_link = commit_pc[gi*ADDR +: ADDR] + ADDR'(4);

      assign w_gpr_idx[gi] = commit_addr[gi*GPR_ADDR +: GPR_ADDR];
      assign w_fpr_idx[gi] = commit_addr[gi*GPR_ADDR +: FPR_ADDR];

      assign w_gpr_wdata[gi] = commit_jump_[gi] ? w_data : DATA'(w_link);

      // FPR destinations never take a link value.
      assign w_fpr_wdata[gi] = w_data;

      // Writes to x0 are dropped here, so both the array and the bypass ignore them.
      assign w_gpr_we[gi] = ~commit_e_[gi] && (w_type == TYPE_GPR) &&
                            (w_gpr_idx[gi] != '0);
      assign w_fpr_we[gi] = ~commit_e_[gi] && (w_type == TYPE_FPR);
    end
  endgenerate

  // Count the valid slots this cycle. Every valid slot retires, whatever its
  // destination type.
  always_comb begin
    w_retire = '0;
    for (int s = 0; s < COMMIT; s++) begin
      if (!commit_e_[s]) w_retire = w_retire + CNT'(1);
    end
  end

  // Retired-instruction counter. It wraps naturally at 2^CNT.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_instret <= '0;
    else         r_instret <= r_instret + w_retire;
  end

  assign instret = r_instret;

  // GPR array update. Slots are applied in ascending order, so the youngest
  // writer of a register wins.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NGPR; i++) r_gpr[i] <= '0;
    end else begin
      for (int s = 0; s < COMMIT; s++) begin
        if (w_gpr_we[s]) r_gpr[w_gpr_idx[s]] <= w_gpr_wdata[s];
      end
    end
  end

  // FPR array update. Same youngest-wins ordering; f0 is an ordinary register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NFPR; i++) r_fpr[i] <= '0;
    end else begin
      for (int s = 0; s < COMMIT; s++) begin
        if (w_fpr_we[s]) r_fpr[w_fpr_idx[s]] <= w_fpr_wdata[s];
      end
    end
  end

  generate
    for (gi = 0; gi < READ; gi++) begin : g_rd
      logic [GPR_ADDR-1:0] w_ga;
      logic [FPR_ADDR-1:0] w_fa;
      logic [DATA-1:0]     w_gd;
      logic [DATA-1:0]     w_fd;

      assign w_ga = issue_gpr_addr[gi*GPR_ADDR +: GPR_ADDR];
      assign w_fa = issue_fpr_addr[gi*FPR_ADDR +: FPR_ADDR];

      // GPR read: array value, overridden by the youngest matching commit.
      // x0 is forced to zero last.
      always_comb begin
        w_gd = r_gpr[w_ga];
        for (int s = 0; s < COMMIT; s++) begin
          if (w_gpr_we[s] && (w_gpr_idx[s] == w_ga)) w_gd = w_gpr_wdata[s];
        end
        if (w_ga == '0) w_gd = '0;
      end

      // FPR read: array value, overridden by the youngest matching commit.
      always_comb begin
        w_fd = r_fpr[w_fa];
        for (int s = 0; s < COMMIT; s++) begin
          if (w_fpr_we[s] && (w_fpr_idx[s] == w_fa)) w_fd = w_fpr_wdata[s];
        end
      end

      assign issue_gpr_data[gi*DATA +: DATA] = w_gd;
      assign issue_fpr_data[gi*DATA +: DATA] = w_fd;
    end
  endgenerate

endmodule

// File: tb/tb_cpu_regfiles_mc.sv
// tb_cpu_regfiles_mc: directed test of cpu_regfiles_mc against a behavioural
// model of the architectural state. The counter width is 4, so wrap-around is
// reachable in a few cycles.
module tb_cpu_regfiles_mc;

  localparam int         DATA = 32, ADDR = 32, GA = 5, FA = 5, READ = 2, COMMIT = 2, CNT = 4;
  localparam logic [1:0] T_GPR = 2'd1, T_FPR = 2'd2, T_OTH = 2'd3;

  logic                 clk = 1'b0;
  logic                 reset_;
  logic [READ*GA-1:0]   issue_gpr_addr;
  logic [READ*DATA-1:0] issue_gpr_data;
  logic [READ*FA-1:0]   issue_fpr_addr;
  logic [READ*DATA-1:0] issue_fpr_data;
  logic [COMMIT-1:0]    commit_e_;
  logic [COMMIT-1:0]    commit_jump_;
  logic [COMMIT*2-1:0]  commit_regtype;
  logic [COMMIT*GA-1:0] commit_addr;
  logic [COMMIT*DATA-1:0] commit_data;
  logic [COMMIT*ADDR-1:0] commit_pc;
  logic [CNT-1:0]       instret;

  cpu_regfiles_mc #(
    .DATA(DATA), .ADDR(ADDR), .GPR_ADDR(GA), .FPR_ADDR(FA), .READ(READ),
    .COMMIT(COMMIT), .CNT(CNT), .TYPE_GPR(T_GPR), .TYPE_FPR(T_FPR)
  ) dut (
    .clk(clk), .reset_(reset_),
    .issue_gpr_addr(issue_gpr_addr), .issue_gpr_data(issue_gpr_data),
    .issue_fpr_addr(issue_fpr_addr), .issue_fpr_data(issue_fpr_data),
    .commit_e_(commit_e_), .commit_jump_(commit_jump_),
    .commit_regtype(commit_regtype), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_pc(commit_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural register contents and retired count.
  logic [31:0] m_gpr [32];
  logic [31:0] m_fpr [32];
  logic [3:0]  m_cnt;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot_data(input int s);
    return commit_data[s*32 +: 32];
  endfunction

  // Value a slot would put into a GPR: the link address (PC+4, 32-bit wrap) or the result.
  function automatic logic [31:0] slot_gpr_val(input int s);
    logic [31:0] pc;
    pc = commit_pc[s*32 +: 32];
    if (!commit_jump_[s]) return pc + 32'd4;
    return slot_data(s);
  endfunction

  function automatic bit slot_is(input int s, input logic [1:0] t);
    return !commit_e_[s] && (commit_regtype[s*2 +: 2] == t);
  endfunction

  // Expected GPR read: the youngest in-flight writer, else the stored value.
  // x0 always reads zero.
  function automatic logic [31:0] exp_gpr(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_gpr[a];
    for (int s = 0; s < COMMIT; s++)
      if (slot_is(s, T_GPR) && commit_addr[s*5 +: 5] == a) v = slot_gpr_val(s);
    return v;
  endfunction

  // Expected FPR read: the youngest in-flight writer, else the stored value.
  function automatic logic [31:0] exp_fpr(input logic [4:0] a);
    logic [31:0] v;
    v = m_fpr[a];
    for (int s = 0; s < COMMIT; s++)
      if (slot_is(s, T_FPR) && commit_addr[s*5 +: 5] == a) v = slot_data(s);
    return v;
  endfunction

  // Retire this cycle's commits in program order.
  task automatic model_commit();
    for (int s = 0; s < COMMIT; s++) begin
      if (!commit_e_[s]) begin
        if (slot_is(s, T_GPR) && commit_addr[s*5 +: 5] != 5'd0)
          m_gpr[commit_addr[s*5 +: 5]] = slot_gpr_val(s);
        if (slot_is(s, T_FPR)) m_fpr[commit_addr[s*5 +: 5]] = slot_data(s);
        m_cnt = m_cnt + 4'd1;
      end
    end
  endtask

  task automatic assert_reset();
    reset_ = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = '0;
      m_fpr[i] = '0;
    end
    m_cnt = '0;
  endtask

  // Advance one clock edge; the model retires only when out of reset.
  task automatic step();
    @(posedge clk);
    if (reset_) model_commit();
    #1;
  endtask

  task automatic clear_slots();
    commit_e_      = '1;
    commit_jump_   = '1;
    commit_regtype = '0;
    commit_addr    = '0;
    commit_data    = '0;
    commit_pc      = '0;
  endtask

  task automatic set_slot(input int s, input logic j_, input logic [1:0] t,
                          input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    commit_e_[s]            = 1'b0;
    commit_jump_[s]         = j_;
    commit_regtype[s*2 +: 2] = t;
    commit_addr[s*5 +: 5]   = a;
    commit_data[s*32 +: 32] = d;
    commit_pc[s*32 +: 32]   = pc;
  endtask

  task automatic set_reads(input logic [4:0] g0, input logic [4:0] g1,
                           input logic [4:0] f0, input logic [4:0] f1);
    issue_gpr_addr = {g1, g0};
    issue_fpr_addr = {f1, f0};
  endtask

  // Compare every read port and instret against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < READ; p++) begin
        chk($sformatf("cmp_gpr_rd%0d", p), 64'(issue_gpr_data[p*32 +: 32]),
            64'(exp_gpr(issue_gpr_addr[p*5 +: 5])));
        chk($sformatf("cmp_fpr_rd%0d", p), 64'(issue_fpr_data[p*32 +: 32]),
            64'(exp_fpr(issue_fpr_addr[p*5 +: 5])));
      end
      chk("cmp_instret", 64'(instret), 64'(m_cnt));
    end
  end

  initial begin
    reset_ = 1'b1;
    clear_slots();
    set_reads(5'd5, 5'd6, 5'd5, 5'd6);
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = '0;
      m_fpr[i] = '0;
    end
    m_cnt = '0;
    #1;
    assert_reset();
    chk_en = 1'b1;

    // Reset held while both slots commit; reads of other registers return 0.
    set_slot(0, 1'b1, T_GPR, 5'd3, 32'h0000AAAA, 32'h0);
    set_slot(1, 1'b1, T_FPR, 5'd4, 32'h0000BBBB, 32'h0);
    #1;
    chk("rst_gpr_x5", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("rst_gpr_x6", 64'(issue_gpr_data[63:32]), 64'h0);
    chk("rst_fpr_f5", 64'(issue_fpr_data[31:0]), 64'h0);
    chk("rst_instret", 64'(instret), 64'h0);
    step();
    step();
    chk("rst_instret_held", 64'(instret), 64'h0);
    set_reads(5'd5, 5'd3, 5'd5, 5'd4);
    #1;
    chk("rst_bypass_gpr", 64'(issue_gpr_data[63:32]), 64'h0000AAAA);
    chk("rst_bypass_fpr", 64'(issue_fpr_data[63:32]), 64'h0000BBBB);
    step();

    // Release reset; the first edge accepts commits.
    reset_ = 1'b1;
    clear_slots();
    set_slot(0, 1'b1, T_GPR, 5'd5, 32'hDEADBEEF, 32'h0);
    step();
    clear_slots();
    #1;
    chk("post_rst_x5", 64'(issue_gpr_data[31:0]), 64'hDEADBEEF);
    chk("post_rst_x3_lost", 64'(issue_gpr_data[63:32]), 64'h0);
    chk("post_rst_f4_lost", 64'(issue_fpr_data[63:32]), 64'h0);
    chk("post_rst_instret", 64'(instret), 64'd1);

    // Same-register collision; the younger slot wins in the bypass and the array.
    set_slot(0, 1'b1, T_GPR, 5'd7, 32'h11, 32'h0);
    set_slot(1, 1'b1, T_GPR, 5'd7, 32'h22, 32'h0);
    set_reads(5'd7, 5'd5, 5'd0, 5'd0);
    #1;
    chk("coll_bypass", 64'(issue_gpr_data[31:0]), 64'h22);
    step();
    clear_slots();
    #1;
    chk("coll_array", 64'(issue_gpr_data[31:0]), 64'h22);
    chk("coll_instret", 64'(instret), 64'd3);

    // A write to x0 is discarded but still retires.
    set_slot(0, 1'b1, T_GPR, 5'd0, 32'hFFFFFFFF, 32'h0);
    set_reads(5'd0, 5'd7, 5'd0, 5'd0);
    #1;
    chk("x0_bypass", 64'(issue_gpr_data[31:0]), 64'h0);
    step();
    clear_slots();
    #1;
    chk("x0_array", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("x0_instret", 64'(instret), 64'd4);

    // Link writes: PC+4, including wrap of 0xFFFFFFFC to 0.
    set_slot(0, 1'b1, T_GPR, 5'd1, 32'h1234, 32'h0);
    step();
    clear_slots();
    set_reads(5'd1, 5'd2, 5'd0, 5'd0);
    #1;
    chk("link_pre_x1", 64'(issue_gpr_data[31:0]), 64'h1234);
    set_slot(0, 1'b0, T_GPR, 5'd2, 32'h99, 32'h00000100);
    set_slot(1, 1'b0, T_GPR, 5'd1, 32'h55, 32'hFFFFFFFC);
    #1;
    chk("link_bypass_x1", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("link_bypass_x2", 64'(issue_gpr_data[63:32]), 64'h104);
    step();
    clear_slots();
    #1;
    chk("link_wrap_x1", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("link_x2", 64'(issue_gpr_data[63:32]), 64'h104);
    chk("link_instret", 64'(instret), 64'd7);

    // Mixed types: an FPR write that ignores the jump flag, plus a non-register slot.
    set_slot(0, 1'b0, T_FPR, 5'd0, 32'h3F800000, 32'h00000200);
    set_slot(1, 1'b1, T_OTH, 5'd9, 32'h77, 32'h0);
    set_reads(5'd9, 5'd5, 5'd0, 5'd4);
    step();
    clear_slots();
    #1;
    chk("mixed_f0", 64'(issue_fpr_data[31:0]), 64'h3F800000);
    chk("mixed_x9", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("mixed_x5", 64'(issue_gpr_data[63:32]), 64'hDEADBEEF);
    chk("mixed_instret", 64'(instret), 64'd9);

    // Eight double-commit cycles: 9 + 16 wraps back to 9 in a 4-bit counter.
    for (int i = 0; i < 8; i++) begin
      clear_slots();
      set_slot(0, 1'b1, T_GPR, 5'(10 + i), 32'h1000 + 32'(i), 32'h0);
      set_slot(1, 1'b1, T_FPR, 5'(10 + i), 32'h2000 + 32'(i * 3), 32'h0);
      set_reads(5'(10 + i), 5'(9 + i), 5'(10 + i), 5'(9 + i));
      step();
      if (i == 3) chk("roll_mid_instret", 64'(instret), 64'd1);
    end
    clear_slots();
    chk("roll_instret", 64'(instret), 64'd9);
    set_reads(5'd12, 5'd17, 5'd15, 5'd17);
    #1;
    chk("roll_x12", 64'(issue_gpr_data[31:0]), 64'h1002);
    chk("roll_f15", 64'(issue_fpr_data[31:0]), 64'h200F);
    chk("roll_f17", 64'(issue_fpr_data[63:32]), 64'h2015);

    // Mid-cycle reset clears everything at once; commits during reset are lost.
    #1;
    assert_reset();
    #1;
    chk("midrst_instret", 64'(instret), 64'h0);
    chk("midrst_x12", 64'(issue_gpr_data[31:0]), 64'h0);
    chk("midrst_f15", 64'(issue_fpr_data[31:0]), 64'h0);
    set_slot(0, 1'b1, T_GPR, 5'd12, 32'h5A, 32'h0);
    #1;
    chk("midrst_bypass", 64'(issue_gpr_data[31:0]), 64'h5A);
    step();
    clear_slots();
    reset_ = 1'b1;
    #1;
    chk("midrst_lost", 64'(issue_gpr_data[31:0]), 64'h0);
    set_slot(0, 1'b1, T_GPR, 5'd12, 32'hCAFE, 32'h0);
    step();
    clear_slots();
    #1;
    chk("after_rst_x12", 64'(issue_gpr_data[31:0]), 64'hCAFE);
    chk("after_rst_instret", 64'(instret), 64'd1);
    step();
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_regfiles_mc.md
# cpu_regfiles_mc

Multi-commit architectural register file block for the CPU commit stage. It holds the GPR and FPR arrays and accepts up to COMMIT retirements per cycle, resolving same-cycle writes to the same register in program order. Issue-side read ports see a write-through bypass of the current cycle's commits. A retired-instruction counter sits beside the arrays. The block sits between the reorder buffer (commit side) and the issue stage (read side).

## Interface
- DATA, 32, register data width
- ADDR, 32, PC width
- GPR_ADDR, 5, GPR index width (2^GPR_ADDR entries)
- FPR_ADDR, 5, FPR index width (2^FPR_ADDR entries)
- READ, 2, read ports per file
- COMMIT, 2, commit slots per cycle; slot 0 is oldest
- CNT, 64, retired-instruction counter width

- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- issue_gpr_addr  in  READ*GPR_ADDR  GPR read indices, port i at [i*GPR_ADDR +: GPR_ADDR]
- issue_gpr_data  out  READ*DATA  GPR read data
- issue_fpr_addr  in  READ*FPR_ADDR  FPR read indices
- issue_fpr_data  out  READ*DATA  FPR read data
- commit_e_  in  COMMIT  per-slot commit valid, active-low
- commit_jump_  in  COMMIT  per-slot link write (write PC+4), active-low
- commit_regtype  in  COMMIT*2  per-slot destination type: TYPE_GPR, TYPE_FPR, other = no register write
- commit_addr  in  COMMIT*GPR_ADDR  per-slot destination index (FPR slots use the low FPR_ADDR bits)
- commit_data  in  COMMIT*DATA  per-slot result
- commit_pc  in  COMMIT*ADDR  per-slot PC
- instret  out  CNT  retired-instruction count

## Operation
**Write data per slot**
- Write data is commit_pc+4 when commit_jump_ is 0; otherwise it is commit_data.
- The +4 sum is zero-extended or truncated to DATA and wraps modulo 2^ADDR.
- FPR slots always write commit_data; commit_jump_ is ignored for them.

**Write enable per slot**
- GPR write when commit_e_ is 0 and regtype is TYPE_GPR.
- FPR write when commit_e_ is 0 and regtype is TYPE_FPR.
- Any other regtype performs no register write but still counts as retired.
- A GPR write to index 0 is discarded. GPR x0 always reads 0. FPR f0 is an ordinary register.

**Same-cycle collisions**
- When several slots write the same register, the highest-numbered valid slot wins.

**Reads**
- Reads are combinational from the array.
- Bypass: if any valid slot in the current cycle writes the addressed register, the read returns that write's data, using the same highest-slot-wins rule.
- A GPR read of index 0 returns 0 regardless of any bypass.

**Counter**
- instret increments each cycle by the number of slots with commit_e_ = 0 (0..COMMIT).
- It wraps modulo 2^CNT and has no saturation.

**Reset**
- Asynchronous assertion of reset_ clears every GPR, every FPR and instret to 0.
- This applies immediately, mid-cycle and irrespective of commits.
- Read outputs reflect the zeroed arrays while reset is asserted; the bypass path is still active.
- Commits presented during reset are lost.

## Timing
- Arrays and instret update on the rising clk edge.
- Write latency is 0 cycles to read ports (bypass) and 1 cycle to array state.
- Read latency is 0 cycles (combinational); there are no stalls and no handshake.
- The commit side must present only in-order, already-resolved retirements.
- instret is registered: the cycle's commits become visible on the following cycle.
- Deassertion of reset_ is synchronised externally. The first edge after deassertion accepts commits normally.

## Test plan
- **Reset:** hold reset_=0 with all slots committing. All reads return 0 and instret=0. Release reset_, commit slot0 GPR x5=0xDEADBEEF. Next cycle x5 reads 0xDEADBEEF and instret=1.
- **Collision and bypass:** same cycle, slot0 GPR x7=0x11 and slot1 GPR x7=0x22, with a read of x7 in that cycle. Read returns 0x22 in the same cycle and x7=0x22 afterwards.
- **Zero register:** slot0 GPR x0=0xFFFFFFFF. Read of x0 returns 0 in the same cycle and the next. instret increments by 1.
- **Link write and wrap:** slot1 GPR x1 with commit_jump_=0, commit_pc=0xFFFFFFFC, commit_data=0x55. x1 becomes 0x00000000.
- **Mixed types:** slot0 FPR f0=0x3F800000, slot1 regtype other. f0 reads 0x3F800000, no GPR changes, instret increments by 2.
- **Counter rollover and mid-run reset:** with CNT=4, 8 cycles of two commits each take instret 0→0 (wrap). Asserting reset_ mid-cycle zeroes instret and all registers immediately.
